// File: rtl/avaliador_jogada_pkg.sv
// Shared types and constants for the music-game step judge.
package avaliador_jogada_pkg;

  localparam int BOTAO_W = 4;
  localparam int VIDAS_W = 3;

  localparam logic [BOTAO_W-1:0] BOTAO_NENHUM = 4'd0;

  // Codes are shown on the debug 7-seg display, so keep them stable.
  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    ESPERA    = 3'd1,
    MEDE      = 3'd2,
    AVALIA    = 3'd3,
    RESULTADO = 3'd4
  } estado_t;

endpackage

// File: rtl/avaliador_jogada_contador_sat.sv
// Saturating tick counter: synchronous clear, count enable, stops at MAX.
// fim flags that the counter is sitting at MAX.
module avaliador_jogada_contador_sat #(
  parameter int W   = 16,
  parameter int MAX = (1 << W) - 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] valor,
  output logic         fim
);

  logic [W-1:0] valor_q;
  logic [W-1:0] valor_d;

  // Next count: clear has priority, counting stops at MAX.
  always_comb begin
    valor_d = valor_q;
    if (zera) begin
      valor_d = '0;
    end else if (conta && (valor_q != W'(MAX))) begin
      valor_d = valor_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

  assign valor = valor_q;
  assign fim   = (valor_q == W'(MAX));

endmodule

// File: rtl/avaliador_jogada.sv
// avaliador_jogada: per-step judge for the music game. Waits for a press,
// measures the hold in metronome ticks, grades note and timing against a
// tolerance window and keeps the player's lives counter.
//
//  state     | meaning
//  OCIOSO    | idle, waiting for inicia
//  ESPERA    | step armed, waiting for first press or timeout
//  MEDE      | note held, counting ticks
//  AVALIA    | grades being registered
//  RESULTADO | resultado_valido pulse, lives updated
module avaliador_jogada
  import avaliador_jogada_pkg::*;
#(
  parameter int NOTAS   = 12,
  parameter int TEMPO_W = 16,
  parameter int TIMEOUT = 64,
  parameter int VIDAS   = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicia,
  input  logic               recarrega,
  input  logic               tick,
  input  logic [BOTAO_W-1:0] botoes_encoded,
  input  logic [BOTAO_W-1:0] nota_esperada,
  input  logic [TEMPO_W-1:0] tempo_esperado,
  input  logic [TEMPO_W-1:0] tolerancia,
  output logic               ocupado,
  output logic               resultado_valido,
  output logic               nota_correta,
  output logic               tempo_correto,
  output logic               tempo_baixo,
  output logic               tempo_alto,
  output logic               perdeu_nota,
  output logic [TEMPO_W-1:0] duracao_medida,
  output logic [VIDAS_W-1:0] vidas_restantes,
  output logic               sem_vidas,
  output logic [2:0]         db_estado
);

  // Timeout counter parks at TIMEOUT-1; the next idle tick is the TIMEOUT-th.
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  estado_t estado_q, estado_d;

  logic [BOTAO_W-1:0] nota_esp_q, nota_esp_d;
  logic [BOTAO_W-1:0] codigo_q, codigo_d;
  logic [TEMPO_W-1:0] tempo_esp_q, tempo_esp_d;
  logic [TEMPO_W-1:0] tol_q, tol_d;
  logic               perdeu_q, perdeu_d;
  logic               nota_ok_q, nota_ok_d;
  logic               tempo_ok_q, tempo_ok_d;
  logic               baixo_q, baixo_d;
  logic               alto_q, alto_d;
  logic [VIDAS_W-1:0] vidas_q, vidas_d;
  logic               sem_vidas_q, sem_vidas_d;

  logic               aceita;
  logic               press;
  logic               solto;
  logic               to_conta;
  logic               to_fim;
  logic               timeout;
  logic [TO_W-1:0]    to_val;
  logic               dur_conta;
  logic               dur_fim;
  logic               estouro;
  logic [TEMPO_W-1:0] dur_val;
  logic [TEMPO_W:0]   dur_ext;
  logic [TEMPO_W:0]   soma;
  logic [TEMPO_W:0]   lim_alto;
  logic [TEMPO_W:0]   lim_baixo;
  logic               nota_valida;
  logic               erro;

  assign aceita   = (estado_q == OCIOSO) && inicia;
  assign press    = (botoes_encoded != BOTAO_NENHUM);
  assign solto    = !press || (botoes_encoded != codigo_q);
  // A press in the same cycle as a tick wins; that tick is not a timeout tick.
  assign to_conta = (estado_q == ESPERA) && tick && !press;
  assign timeout  = to_conta && to_fim;
  // Release and tick together: the tick is dropped.
  assign dur_conta = (estado_q == MEDE) && tick && !solto;

  assign dur_ext   = {1'b0, dur_val};
  assign soma      = {1'b0, tempo_esp_q} + {1'b0, tol_q};
  assign lim_alto  = soma[TEMPO_W] ? {1'b0, {TEMPO_W{1'b1}}} : soma;
  assign lim_baixo = (tempo_esp_q >= tol_q) ? {1'b0, tempo_esp_q - tol_q} : '0;
  // This tick lifts the count past the window; a saturated window can't be exceeded.
  assign estouro   = dur_conta && (dur_ext == lim_alto) && !dur_fim;

  assign nota_valida = (int'(codigo_q) <= NOTAS);
  assign erro        = perdeu_q || !nota_ok_q || !tempo_ok_q;

  avaliador_jogada_contador_sat #(
    .W   (TEMPO_W)
  ) u_dur (
    .clock (clock),
    .reset (reset),
    .zera  (aceita),
    .conta (dur_conta),
    .valor (dur_val),
    .fim   (dur_fim)
  );

  avaliador_jogada_contador_sat #(
    .W   (TO_W),
    .MAX (TIMEOUT - 1)
  ) u_to (
    .clock (clock),
    .reset (reset),
    .zera  (aceita),
    .conta (to_conta),
    .valor (to_val),
    .fim   (to_fim)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      OCIOSO:    if (aceita) estado_d = ESPERA;
      ESPERA: begin
        if (press)        estado_d = MEDE;
        else if (timeout) estado_d = AVALIA;
      end
      MEDE:      if (solto || estouro) estado_d = AVALIA;
      AVALIA:    estado_d = RESULTADO;
      RESULTADO: estado_d = OCIOSO;
      default:   estado_d = OCIOSO;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ocupado          = (estado_q != OCIOSO);
    resultado_valido = (estado_q == RESULTADO);
    db_estado        = estado_q;
  end

  // Step latches, grades and lives: next values.
  always_comb begin
    nota_esp_d  = nota_esp_q;
    codigo_d    = codigo_q;
    tempo_esp_d = tempo_esp_q;
    tol_d       = tol_q;
    perdeu_d    = perdeu_q;
    nota_ok_d   = nota_ok_q;
    tempo_ok_d  = tempo_ok_q;
    baixo_d     = baixo_q;
    alto_d      = alto_q;
    vidas_d     = vidas_q;
    sem_vidas_d = sem_vidas_q;

    if (aceita) begin
      nota_esp_d  = nota_esperada;
      tempo_esp_d = tempo_esperado;
      tol_d       = tolerancia;
      codigo_d    = BOTAO_NENHUM;
      perdeu_d    = 1'b0;
      nota_ok_d   = 1'b0;
      tempo_ok_d  = 1'b0;
      baixo_d     = 1'b0;
      alto_d      = 1'b0;
    end

    if ((estado_q == ESPERA) && press) begin
      codigo_d = botoes_encoded;
    end
    if (timeout) begin
      perdeu_d = 1'b1;
    end

    if (estado_q == AVALIA) begin
      if (perdeu_q) begin
        nota_ok_d  = 1'b0;
        tempo_ok_d = 1'b0;
        baixo_d    = 1'b0;
        alto_d     = 1'b0;
      end else begin
        nota_ok_d  = nota_valida && (codigo_q == nota_esp_q);
        baixo_d    = (dur_ext < lim_baixo);
        alto_d     = (dur_ext > lim_alto);
        tempo_ok_d = !(dur_ext < lim_baixo) && !(dur_ext > lim_alto);
      end
    end

    // Reload beats a same-cycle decrement; with VIDAS=0 the count stays at 0.
    if (recarrega) begin
      vidas_d     = VIDAS_W'(VIDAS);
      sem_vidas_d = 1'b0;
    end else if ((estado_q == RESULTADO) && erro && (vidas_q != '0)) begin
      vidas_d     = vidas_q - 1'b1;
      sem_vidas_d = (vidas_q == VIDAS_W'(1));
    end
  end

  // Step latches, grades and lives: registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nota_esp_q  <= BOTAO_NENHUM;
      codigo_q    <= BOTAO_NENHUM;
      tempo_esp_q <= '0;
      tol_q       <= '0;
      perdeu_q    <= 1'b0;
      nota_ok_q   <= 1'b0;
      tempo_ok_q  <= 1'b0;
      baixo_q     <= 1'b0;
      alto_q      <= 1'b0;
      vidas_q     <= VIDAS_W'(VIDAS);
      sem_vidas_q <= 1'b0;
    end else begin
      nota_esp_q  <= nota_esp_d;
      codigo_q    <= codigo_d;
      tempo_esp_q <= tempo_esp_d;
      tol_q       <= tol_d;
      perdeu_q    <= perdeu_d;
      nota_ok_q   <= nota_ok_d;
      tempo_ok_q  <= tempo_ok_d;
      baixo_q     <= baixo_d;
      alto_q      <= alto_d;
      vidas_q     <= vidas_d;
      sem_vidas_q <= sem_vidas_d;
    end
  end

  assign nota_correta    = nota_ok_q;
  assign tempo_correto   = tempo_ok_q;
  assign tempo_baixo     = baixo_q;
  assign tempo_alto      = alto_q;
  assign perdeu_nota     = perdeu_q;
  assign duracao_medida  = dur_val;
  assign vidas_restantes = vidas_q;
  assign sem_vidas       = sem_vidas_q;

endmodule

// File: tb/tb_avaliador_jogada.sv
// Self-checking bench for avaliador_jogada: directed game scenarios plus
// randomized steps graded by an arithmetic model of the judging rules.
module tb_avaliador_jogada;

  localparam int TEMPO_W = 16;
  localparam int TIMEOUT = 64;
  localparam int VIDAS   = 3;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               inicia = 1'b0;
  logic               recarrega = 1'b0;
  logic               tick = 1'b0;
  logic [3:0]         botoes_encoded = '0;
  logic [3:0]         nota_esperada = '0;
  logic [TEMPO_W-1:0] tempo_esperado = '0;
  logic [TEMPO_W-1:0] tolerancia = '0;
  logic               ocupado;
  logic               resultado_valido;
  logic               nota_correta;
  logic               tempo_correto;
  logic               tempo_baixo;
  logic               tempo_alto;
  logic               perdeu_nota;
  logic [TEMPO_W-1:0] duracao_medida;
  logic [2:0]         vidas_restantes;
  logic               sem_vidas;
  logic [2:0]         db_estado;

  int checks   = 0;
  int failures = 0;
  int vidas_m  = VIDAS;
  bit sem_m    = 1'b0;

  avaliador_jogada #(
    .NOTAS   (12),
    .TEMPO_W (TEMPO_W),
    .TIMEOUT (TIMEOUT),
    .VIDAS   (VIDAS)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .inicia           (inicia),
    .recarrega        (recarrega),
    .tick             (tick),
    .botoes_encoded   (botoes_encoded),
    .nota_esperada    (nota_esperada),
    .tempo_esperado   (tempo_esperado),
    .tolerancia       (tolerancia),
    .ocupado          (ocupado),
    .resultado_valido (resultado_valido),
    .nota_correta     (nota_correta),
    .tempo_correto    (tempo_correto),
    .tempo_baixo      (tempo_baixo),
    .tempo_alto       (tempo_alto),
    .perdeu_nota      (perdeu_nota),
    .duracao_medida   (duracao_medida),
    .vidas_restantes  (vidas_restantes),
    .sem_vidas        (sem_vidas),
    .db_estado        (db_estado)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  // One clock of stimulus, applied at the falling edge; optional noise on
  // inicia and the expected-value buses while the judge is busy.
  task automatic ciclo(input logic t, input logic [3:0] b, input bit ruido);
    tick = t;
    botoes_encoded = b;
    if (ruido) begin
      inicia         = ($urandom_range(0, 3) == 0);
      nota_esperada  = 4'($urandom_range(0, 15));
      tempo_esperado = 16'($urandom);
      tolerancia     = 16'($urandom);
    end
    @(negedge clock);
    tick = 1'b0;
    if (ruido) inicia = 1'b0;
  endtask

  task automatic folga(input logic [3:0] b);
    repeat ($urandom_range(0, 2)) ciclo(1'b0, b, 1'b1);
  endtask

  // One full step. modo: 0 plain release, 1 release with tick, 2 switch to another code.
  // tp: tick on the press cycle (0/1), 2 = random.
  task automatic passo(input logic [3:0] nota, input int esp, input int tol, input int pre,
                       input logic [3:0] cod, input int hold, input int modo,
                       input bit recarga_junto, input int tp);
    int lo, hi, med, n, nt;
    bit perdeu, overhold, nota_m, baixo_m, alto_m, ok_m, erro;
    logic [3:0] cod2;
    lo       = (esp > tol) ? esp - tol : 0;
    hi       = (esp + tol > 65535) ? 65535 : esp + tol;
    perdeu   = (pre >= TIMEOUT);
    overhold = !perdeu && (hold >= hi + 1);
    med      = perdeu ? 0 : (overhold ? hi + 1 : hold);
    cod2     = (cod % 12) + 1;

    nota_esperada  = nota;
    tempo_esperado = 16'(esp);
    tolerancia     = 16'(tol);
    inicia         = 1'b1;
    ciclo(1'b0, 4'd0, 1'b0);
    inicia = 1'b0;
    verifica("ocupado_inicio", 32'(ocupado), 1);

    n = perdeu ? TIMEOUT : pre;
    for (int i = 0; i < n; i++) begin
      folga(4'd0);
      ciclo(1'b1, 4'd0, 1'b1);
    end
    if (!perdeu) begin
      ciclo((tp == 2) ? 1'($urandom_range(0, 1)) : 1'(tp), cod, 1'b1);
      nt = overhold ? hi + 1 : hold;
      for (int i = 0; i < nt; i++) begin
        folga(cod);
        ciclo(1'b1, cod, 1'b1);
      end
      if (!overhold) begin
        if (modo == 1)      ciclo(1'b1, 4'd0, 1'b1);
        else if (modo == 2) ciclo(1'($urandom_range(0, 1)), cod2, 1'b1);
        else                ciclo(1'b0, 4'd0, 1'b1);
      end
    end

    n = 0;
    while (resultado_valido !== 1'b1 && n < 8) begin
      @(negedge clock);
      n++;
    end
    verifica("latencia", 32'(n), 1);

    if (recarga_junto) recarrega = 1'b1;
    ciclo(1'b0, 4'd0, 1'b0);
    recarrega = 1'b0;

    nota_m  = !perdeu && (cod == nota);
    baixo_m = !perdeu && (med < lo);
    alto_m  = !perdeu && (med > hi);
    ok_m    = !perdeu && !baixo_m && !alto_m;
    erro    = perdeu || !nota_m || !ok_m;
    if (recarga_junto) begin
      vidas_m = VIDAS;
      sem_m   = 1'b0;
    end else if (erro && vidas_m > 0) begin
      vidas_m--;
      if (vidas_m == 0) sem_m = 1'b1;
    end

    verifica("pulso_unico", 32'(resultado_valido), 0);
    verifica("ocupado_fim", 32'(ocupado), 0);
    verifica("perdeu_nota", 32'(perdeu_nota), 32'(perdeu));
    verifica("nota_correta", 32'(nota_correta), 32'(nota_m));
    verifica("tempo_correto", 32'(tempo_correto), 32'(ok_m));
    verifica("tempo_baixo", 32'(tempo_baixo), 32'(baixo_m));
    verifica("tempo_alto", 32'(tempo_alto), 32'(alto_m));
    verifica("duracao", 32'(duracao_medida), 32'(med));
    verifica("vidas", 32'(vidas_restantes), 32'(vidas_m));
    verifica("sem_vidas", 32'(sem_vidas), 32'(sem_m));
  endtask

  task automatic recarga_ocioso();
    recarrega = 1'b1;
    ciclo(1'b0, 4'd0, 1'b0);
    recarrega = 1'b0;
    vidas_m = VIDAS;
    sem_m   = 1'b0;
    verifica("recarga_vidas", 32'(vidas_restantes), 32'(VIDAS));
    verifica("recarga_sem", 32'(sem_vidas), 0);
  endtask

  task automatic reset_em_mede();
    int vistos;
    vistos = 0;
    nota_esperada  = 4'd5;
    tempo_esperado = 16'd8;
    tolerancia     = 16'd1;
    inicia = 1'b1;
    ciclo(1'b0, 4'd0, 1'b0);
    inicia = 1'b0;
    ciclo(1'b0, 4'd5, 1'b0);
    ciclo(1'b1, 4'd5, 1'b0);
    ciclo(1'b1, 4'd5, 1'b0);
    verifica("estado_mede", 32'(db_estado), 2);
    verifica("duracao_antes_reset", 32'(duracao_medida), 2);
    reset = 1'b0;
    #2;
    verifica("reset_estado", 32'(db_estado), 0);
    verifica("reset_ocupado", 32'(ocupado), 0);
    verifica("reset_duracao", 32'(duracao_medida), 0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ciclo(1'(i % 2), 4'd5, 1'b0);
      if (resultado_valido === 1'b1 || ocupado === 1'b1) vistos++;
    end
    ciclo(1'b0, 4'd0, 1'b0);
    verifica("sem_resultado_apos_reset", 32'(vistos), 0);
    vidas_m = VIDAS;
    sem_m   = 1'b0;
    verifica("reset_vidas", 32'(vidas_restantes), 32'(VIDAS));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0] nota, cod;
    int esp, tol, pre, hold, modo, r;
    bit rj;

    repeat (3) @(negedge clock);
    verifica("rst_ocupado", 32'(ocupado), 0);
    verifica("rst_resultado", 32'(resultado_valido), 0);
    verifica("rst_grades", 32'({nota_correta, tempo_correto, tempo_baixo, tempo_alto, perdeu_nota}), 0);
    verifica("rst_duracao", 32'(duracao_medida), 0);
    verifica("rst_vidas", 32'(vidas_restantes), 32'(VIDAS));
    verifica("rst_sem_vidas", 32'(sem_vidas), 0);
    verifica("rst_estado", 32'(db_estado), 0);
    reset = 1'b1;
    @(negedge clock);

    passo(4'd5, 8, 1, 2, 4'd5, 8, 0, 1'b0, 0);      // exact hit
    passo(4'd5, 8, 1, 1, 4'd5, 5, 0, 1'b0, 0);      // early release
    passo(4'd2, 4, 0, 0, 4'd2, 20, 0, 1'b0, 0);     // overhold -> result on 5th tick
    recarga_ocioso();
    repeat (4) passo(4'd1, 5, 1, TIMEOUT, 4'd1, 0, 0, 1'b0, 0); // timeouts down to floor 0
    recarga_ocioso();
    passo(4'd7, 4, 2, 1, 4'd3, 4, 0, 1'b0, 0);      // wrong note
    passo(4'd6, 6, 0, 1, 4'd6, 6, 1, 1'b0, 0);      // release coincident with tick
    passo(4'd4, 2, 5, 0, 4'd4, 0, 0, 1'b0, 1);      // lower bound saturates at 0
    passo(4'd4, 65520, 32, 0, 4'd4, 3, 2, 1'b0, 0); // upper bound saturates, code switch
    passo(4'd9, 3, 0, 0, 4'd1, 3, 0, 1'b1, 0);      // reload beats decrement
    passo(4'd8, 2, 1, TIMEOUT - 1, 4'd8, 2, 0, 1'b0, 1); // press with would-be last timeout tick
    reset_em_mede();

    for (int k = 0; k < 40; k++) begin
      nota = 4'($urandom_range(1, 12));
      cod  = ($urandom_range(0, 1) == 1) ? nota : 4'($urandom_range(1, 12));
      esp  = $urandom_range(0, 12);
      tol  = $urandom_range(0, 3);
      r    = $urandom_range(0, 9);
      pre  = (r == 0) ? TIMEOUT : ((r == 1) ? TIMEOUT - 1 : $urandom_range(0, 4));
      hold = $urandom_range(0, 16);
      modo = $urandom_range(0, 2);
      rj   = ($urandom_range(0, 7) == 0);
      passo(nota, esp, tol, pre, cod, hold, modo, rj, 2);
      if (vidas_m == 0 && $urandom_range(0, 1) == 1) recarga_ocioso();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
